// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// Default widths/depth, the buffered {pc, inst} entry, and counter sizing.
package ifu_pkg;

  localparam int IFU_PC_W   = 32;
  localparam int IFU_INST_W = 32;
  localparam int IFU_DEPTH  = 2;
  localparam logic [IFU_PC_W-1:0] IFU_RESET_PC = 32'h8000_0000;
  localparam int IFU_CNT_W  = $clog2(IFU_DEPTH + 1);

  typedef struct packed {
    logic [IFU_PC_W-1:0]   pc;
    logic [IFU_INST_W-1:0] inst;
  } fetch_entry_t;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer with a combinational head; flush clears it in one cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import ifu_pkg::*;
#(
  parameter int  DEPTH   = IFU_DEPTH,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   enq_i,
  input  logic   deq_i,
  input  logic   flush_i,
  input  entry_t enq_data_i,
  output logic   full_o,
  output logic   empty_o,
  output entry_t head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq_i) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({enq_i, deq_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_i && !flush_i && !rst_i) mem_q[wr_ptr_q] <= enq_data_i;
  end

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// PC generation and fetch buffering in front of a combinational instruction ROM.
// Redirects realign the PC and flush wrong-path entries from the buffer.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int              PC_W     = IFU_PC_W,
  parameter int              INST_W   = IFU_INST_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(IFU_RESET_PC),
  parameter int              DEPTH    = IFU_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [PC_W-1:0]   pc_o,
  input  logic [INST_W-1:0] inst_i,
  output logic              fetch_o,
  input  logic              redirect_valid_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   out_pc_o,
  output logic [INST_W-1:0] out_inst_o
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [PC_W-1:0] pc_q, pc_d;
  logic            full, empty, deq, fetch;
  entry_t          head, enq_data;

  assign out_valid_o = !rst_i && !empty;
  assign deq         = out_valid_o && out_ready_i;
  // A full buffer can still accept when its head leaves in the same cycle.
  assign fetch       = !rst_i && !redirect_valid_i && (!full || deq);
  assign fetch_o     = fetch;

  assign pc_o       = rst_i ? RESET_PC : pc_q;
  assign out_pc_o   = rst_i ? '0 : head.pc;
  assign out_inst_o = rst_i ? '0 : head.inst;
  assign enq_data   = '{pc: pc_q, inst: inst_i};

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) pc_d = {redirect_pc_i[PC_W-1:2], 2'b00};
    else if (fetch)       pc_d = pc_q + PC_W'(4);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .entry_t(entry_t)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .enq_i     (fetch),
    .deq_i     (deq),
    .flush_i   (redirect_valid_i),
    .enq_data_i(enq_data),
    .full_o    (full),
    .empty_o   (empty),
    .head_o    (head)
  );

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Scoreboard bench for ifu_fetch_ctrl: a queue-based reference model predicts
// per-cycle control outputs and delivered {pc, inst} pairs; a monitor checks them.
module tb_ifu_fetch_ctrl;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] pc_o;
  logic [31:0] inst_i;
  logic        fetch_o;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] out_pc_o;
  logic [31:0] out_inst_o;

  always #5 clk_i = ~clk_i;

  // ROM model: instruction is the bitwise complement of its address.
  assign inst_i = pc_o ^ 32'hFFFF_FFFF;

  ifu_fetch_ctrl #(
    .PC_W    (32),
    .INST_W  (32),
    .RESET_PC(RST_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pc_o            (pc_o),
    .inst_i          (inst_i),
    .fetch_o         (fetch_o),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_pc_o        (out_pc_o),
    .out_inst_o      (out_inst_o)
  );

  typedef struct {
    logic        f;
    logic [31:0] pc;
    logic        v;
    logic        r;
  } cyc_t;

  logic [63:0] m_fifo[$];
  logic [63:0] sb[$];
  cyc_t        cyc_q[$];
  logic [31:0] m_pc = RST_PC;
  int          n_checks = 0;
  int          n_fail = 0;

  // Reference model: evaluated mid-cycle from the inputs it drove and its own state.
  initial begin
    bit   deq_m, fetch_m;
    cyc_t c;
    forever begin
      @(negedge clk_i);
      deq_m   = !rst_i && (m_fifo.size() != 0) && out_ready_i;
      fetch_m = !rst_i && !redirect_valid_i && ((m_fifo.size() < DEPTH) || deq_m);
      c.f  = fetch_m;
      c.pc = rst_i ? RST_PC : m_pc;
      c.v  = !rst_i && (m_fifo.size() != 0);
      c.r  = rst_i;
      cyc_q.push_back(c);
      if (deq_m) sb.push_back(m_fifo.pop_front());
      if (rst_i) begin
        m_pc = RST_PC;
        m_fifo.delete();
      end else if (redirect_valid_i) begin
        m_pc = redirect_pc_i & ~32'd3;
        m_fifo.delete();
      end else if (fetch_m) begin
        m_fifo.push_back({m_pc, m_pc ^ 32'hFFFF_FFFF});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares control outputs every cycle and pops the scoreboard on each transfer.
  initial begin
    cyc_t        c;
    logic [63:0] e;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_inst = '0;
    forever begin
      @(negedge clk_i);
      #1;
      if (cyc_q.size() != 0) begin
        c = cyc_q.pop_front();
        check("fetch_o", {31'b0, fetch_o}, {31'b0, c.f});
        check("pc_o", pc_o, c.pc);
        check("out_valid_o", {31'b0, out_valid_o}, {31'b0, c.v});
        if (c.r) begin
          check("rst_out_pc", out_pc_o, 32'h0);
          check("rst_out_inst", out_inst_o, 32'h0);
        end else if (out_valid_o && out_ready_i) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_xfer: got pc=%h inst=%h expected no transfer", out_pc_o, out_inst_o);
          end else begin
            e = sb.pop_front();
            $display("xfer pc=%h inst=%h exp_pc=%h exp_inst=%h", out_pc_o, out_inst_o, e[63:32], e[31:0]);
            check("head_pc", out_pc_o, e[63:32]);
            check("head_inst", out_inst_o, e[31:0]);
          end
        end
        if (hold_prev && !rst_i) begin
          check("hold_pc", out_pc_o, prev_pc);
          check("hold_inst", out_inst_o, prev_inst);
        end
      end
      hold_prev = out_valid_o && !out_ready_i && !rst_i && !redirect_valid_i;
      prev_pc   = out_pc_o;
      prev_inst = out_inst_o;
    end
  end

  task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    rst_i            = r;
    out_ready_i      = rdy;
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [31:0] rpc;
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h8000_1003);
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h8000_2000);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h8000_3000);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 600; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), rpc);
    end
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- PC-generation and fetch-buffer stage that sits directly upstream of the instruction ROM.
- Holds the architectural fetch PC and drives it to the ROM; the ROM returns the instruction combinationally in the same cycle.
- Captures each {pc, inst} pair into a small FIFO and presents it to the decode stage over a valid/ready handshake.
- Accepts redirects (jump, branch, trap) from the execute stage; a redirect flushes the buffered, wrong-path instructions.

Parameters:
- PC_W, 32, width of the PC, equal to the width of `ysyx_23060251_pc_bus`.
- INST_W, 32, width of an instruction, equal to the width of `ysyx_23060251_inst_bus`.
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- DEPTH, 2, number of fetch-buffer entries; must be a power of 2 and at least 2.

Ports:
- clk_i  input  1  clock; the block has a single clock.
- rst_i  input  1  reset, synchronous and active-high.
- pc_o  output  PC_W  fetch address driven to the ROM pc_i.
- inst_i  input  INST_W  instruction returned by the ROM for pc_o, valid in the same cycle.
- fetch_o  output  1  a fetch is committed this cycle (inst_i is being captured).
- redirect_valid_i  input  1  execute stage requests a PC redirect.
- redirect_pc_i  input  PC_W  redirect target.
- out_valid_o  output  1  FIFO head is valid.
- out_ready_i  input  1  decode stage accepts the head.
- out_pc_o  output  PC_W  PC of the head entry.
- out_inst_o  output  INST_W  instruction of the head entry.

Behaviour:
- Reset, while rst_i is high at a clock edge:
  - pc_q is set to RESET_PC, count to 0, and the read and write pointers to 0.
  - During reset: out_valid_o=0, fetch_o=0, pc_o=RESET_PC, out_pc_o and out_inst_o read 0.
  - Reset overrides redirects and handshakes in the same cycle.
- pc_o is driven combinationally from pc_q, so the ROM sees pc_q every cycle.
- Dequeue: deq = out_valid_o & out_ready_i. out_valid_o = (count != 0).
- Fetch condition: fetch_o = !rst_i & !redirect_valid_i & ((count < DEPTH) | deq).
  - Enqueueing into a full FIFO in the same cycle as a dequeue is allowed.
- On a fetch: write {pc_q, inst_i} at the write pointer and set pc_q <= pc_q + 4.
  - The PC wraps modulo 2^PC_W; no error is raised.
- On a redirect (redirect_valid_i=1 and not in reset):
  - pc_q <= {redirect_pc_i[PC_W-1:2], 2'b00}; the low two bits are forced to 0.
  - The FIFO is flushed: count=0 and pointers=0 on the next cycle.
  - No fetch occurs that cycle.
  - A dequeue in the same cycle still counts as a transfer. Decode must ignore it; the execute stage owns wrong-path kill.
- Stall (count==DEPTH and !deq): pc_q holds, and pc_o stays stable, so the ROM re-reads the same address harmlessly.
- Count update: count_next = count + fetch_o - deq. Simultaneous fetch and dequeue leaves count unchanged.
- Latency:
  - An instruction fetched in cycle N is visible on out_* in cycle N+1 at the earliest.
  - After a redirect in cycle N, the target is fetched in cycle N+1 and presented in cycle N+2.
- Output stability: while out_valid_o=1 and out_ready_i=0, out_pc_o and out_inst_o must not change unless a redirect occurs.
- Pointers wrap modulo DEPTH.
- Throughput: 1 instruction per cycle whenever out_ready_i is held at 1.

Decomposition:
- Shared package (ifu_pkg):
  - RESET_PC constant.
  - fetch_entry_t struct {pc, inst}.
  - localparam for the count width, $clog2(DEPTH+1).
- Sub-module fetch_fifo:
  - Parameterised on DEPTH and entry type.
  - Provides enq, deq and flush inputs, and full, empty and head outputs.
- The top level holds only pc_q, the fetch/redirect logic and the port wiring.

Test Plan:
- Reset then run with out_ready_i=1 and the ROM model returning inst=pc^32'hFFFF_FFFF → outputs in order (80000000, 7FFFFFFF), (80000004, 7FFFFFFB), …; out_valid_o rises in the first cycle after reset release; one instruction per cycle.
- Hold out_ready_i=0 for 5 cycles → count saturates at 2, pc_o stays 80000008, fetch_o=0, and the head stays 80000000 stable. Then raise ready → 80000000, 80000004, 80000008 delivered in order with no gap.
- Redirect with redirect_pc_i=80001003 while the FIFO holds 2 entries → next cycle out_valid_o=0 and pc_o=80001000; the cycle after, the head is 80001000.
- Redirect on the same cycle as full plus dequeue → no enqueue that cycle, the FIFO is empty afterwards, and fetch resumes at the target.
- Assert rst_i mid-stream with the FIFO full and a redirect pending → next cycle pc_o=80000000, out_valid_o=0; the redirect is ignored.
- Set pc_q near wrap by redirecting to FFFFFFFC → fetches FFFFFFFC then 00000000; no error.
